exc_commit_ctrl: RTL and testbench
==================================

# exc_commit_ctrl

Exception/interrupt commit sequencer between the writeback stage and the CSR file. Once per committing instruction it picks the highest-priority exception, interrupt or ERTN event and sends the one-cycle `wb_ex`/`eret_flush` pulse with ecode/esubcode/pc to the CSR file. It then drains outstanding memory responses and redirects fetch through a valid/ready handshake. While a sequence is in progress it stalls writeback and squashes younger instructions.

## Interface
- Parameters: none.
- Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ws_valid`  in  1  writeback stage holds an instruction.
- `ws_ready`  out  1  writeback may commit (`state==IDLE`).
- `ws_pc`  in  32  PC of the writeback instruction.
- `ws_vaddr`  in  32  memory address of the writeback instruction (ALE).
- `ws_ex_adef`, `ws_ex_ine`, `ws_ex_sys`, `ws_ex_brk`, `ws_ex_ale`  in  1 each  exception flags.
- `ws_ertn`  in  1  instruction is ERTN.
- `int_pending`  in  1  OR of (ESTAT.IS & ECFG.LIE) from the CSR file.
- `crmd_ie`  in  1  CRMD.IE.
- `csr_eentry`  in  32  EENTRY read value.
- `csr_era`  in  32  ERA read value.
- `ws_commit_ok`  out  1  instruction may write GPR/CSR this cycle (no event).
- `wb_ex`  out  1  one-cycle exception pulse to the CSR file.
- `wb_ecode`  out  6  ecode.
- `wb_esubcode`  out  9  esubcode.
- `wb_pc`  out  32  faulting PC.
- `wb_vaddr`  out  32  bad virtual address.
- `eret_flush`  out  1  one-cycle ERTN pulse to the CSR file.
- `mem_pending`  in  1  data-memory responses still outstanding.
- `pipe_kill`  out  1  squash all younger stages.
- `flush_valid`  out  1  redirect request to fetch.
- `flush_target`  out  32  redirect PC.
- `flush_ready`  in  1  fetch accepts the redirect.

## Operation
- States: IDLE, COMMIT, DRAIN, REDIRECT.
- Event detection, in IDLE with `ws_valid`:
  - `int_take = int_pending & crmd_ie`.
  - event = `int_take | any ex flag | ws_ertn`.
  - `ws_commit_ok = ws_valid & (state==IDLE) & ~event`.
- Priority and encoding (first match wins):
  - INT: ecode 0x00.
  - ADEF: ecode 0x08, esub 0.
  - INE: ecode 0x0D.
  - SYS: ecode 0x0B.
  - BRK: ecode 0x0C.
  - ALE: ecode 0x09.
  - ERTN: `eret_flush`, no ecode.
  - esubcode is 0 for every ecode.
  - Any exception overrides a simultaneous `ws_ertn`.
- Latching on the detection edge:
  - `wb_pc` ← `ws_pc`; `wb_vaddr` ← `ws_vaddr` on ALE, `ws_pc` on ADEF, otherwise unchanged.
  - `flush_target` ← `csr_era` for ERTN, otherwise `csr_eentry`.
- Transitions:
  - IDLE→COMMIT on event.
  - COMMIT→DRAIN always.
  - DRAIN→REDIRECT when `mem_pending==0`; DRAIN stays while it is 1.
  - REDIRECT→IDLE on `flush_valid & flush_ready`.
- Outputs per state:
  - COMMIT: `wb_ex` or `eret_flush` = 1 for exactly one cycle.
  - COMMIT, DRAIN, REDIRECT: `pipe_kill` = 1, `ws_ready` = 0.
  - REDIRECT: `flush_valid` = 1. `flush_valid` and `flush_target` stay stable until accepted.
- `wb_ex` and `eret_flush` are never high together and never high outside COMMIT.
- Interrupts are sampled only while `ws_valid` in IDLE, never mid-sequence.

## Timing
- Reset: state IDLE. All outputs are 0 except `ws_ready = 1`: `wb_ex`, `eret_flush`, `pipe_kill`, `flush_valid`, `wb_ecode`, `wb_esubcode`, `wb_pc`, `wb_vaddr`, `flush_target`. Reset mid-sequence drops `flush_valid` and `pipe_kill` the next cycle.
- Event at cycle T:
  - T+1: `wb_ex`/`eret_flush` pulse; the CSR file updates at the end of T+1.
  - `mem_pending==0` at T+2: `flush_valid` rises at T+3.
  - `flush_ready` at T+3: `ws_ready` is 1 at T+4.
- Minimum event-to-next-commit latency: 4 cycles.
- `flush_ready` asserted early (before REDIRECT) is ignored.

## Test plan
- `ws_ex_sys`, pc 0x1C000100, eentry 0x1C008000, `mem_pending`=0, `flush_ready`=1 -> `wb_ex` pulse at T+1 with ecode 0x0B; `flush_valid` with target 0x1C008000 at T+3; `ws_ready` at T+4.
- `ws_ertn`, era 0x1C000204 -> `eret_flush` pulse only, `wb_ex`=0, target 0x1C000204.
- `int_pending`=1, `crmd_ie`=1, together with `ws_ex_ine` and `ws_ertn` -> ecode 0x00, `eret_flush`=0. Same case with `crmd_ie`=0 -> ecode 0x0D.
- ALE with vaddr 0x00000003 and `mem_pending` held 5 cycles -> `wb_vaddr`=0x3; DRAIN for 5 cycles; `pipe_kill` high throughout; `flush_valid` only after `mem_pending` drops.
- `flush_ready` low for 3 cycles in REDIRECT -> `flush_valid` and `flush_target` stable; `ws_commit_ok`=0 throughout.
- Reset asserted in DRAIN -> next cycle IDLE, all outputs at reset values, a new event is handled normally.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt/ERTN commit sequencer: picks the winning event at writeback,
// pulses the CSR file, drains memory responses, then redirects fetch.
module exc_commit_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [31:0] ws_pc,
    input  logic [31:0] ws_vaddr,
    input  logic        ws_ex_adef,
    input  logic        ws_ex_ine,
    input  logic        ws_ex_sys,
    input  logic        ws_ex_brk,
    input  logic        ws_ex_ale,
    input  logic        ws_ertn,
    input  logic        int_pending,
    input  logic        crmd_ie,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        ws_commit_ok,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        eret_flush,
    input  logic        mem_pending,
    output logic        pipe_kill,
    output logic        flush_valid,
    output logic [31:0] flush_target,
    input  logic        flush_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        DRAIN    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_reg;
    logic        int_take;
    logic        has_ex;
    logic        event_det;
    logic [5:0]  ecode_next;
    logic [31:0] vaddr_next;

    // Priority chain: interrupt first, then exceptions in fixed order; ERTN only if nothing else.
    always_comb begin
        int_take   = int_pending & crmd_ie;
        has_ex     = int_take | ws_ex_adef | ws_ex_ine | ws_ex_sys | ws_ex_brk | ws_ex_ale;
        event_det  = ws_valid & (state_reg == IDLE) & (has_ex | ws_ertn);
        ecode_next = wb_ecode;
        vaddr_next = wb_vaddr;
        if (int_take) begin
            ecode_next = 6'h00;
        end else if (ws_ex_adef) begin
            ecode_next = 6'h08;
            vaddr_next = ws_pc;
        end else if (ws_ex_ine) begin
            ecode_next = 6'h0D;
        end else if (ws_ex_sys) begin
            ecode_next = 6'h0B;
        end else if (ws_ex_brk) begin
            ecode_next = 6'h0C;
        end else if (ws_ex_ale) begin
            ecode_next = 6'h09;
            vaddr_next = ws_vaddr;
        end
    end

    assign ws_commit_ok = ws_valid & (state_reg == IDLE) & ~(has_ex | ws_ertn);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ws_ready     <= 1'b1;
            wb_ex        <= 1'b0;
            eret_flush   <= 1'b0;
            wb_ecode     <= '0;
            wb_esubcode  <= '0;
            wb_pc        <= '0;
            wb_vaddr     <= '0;
            pipe_kill    <= 1'b0;
            flush_valid  <= 1'b0;
            flush_target <= '0;
        end else begin
            wb_ex      <= 1'b0;
            eret_flush <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (event_det) begin
                        state_reg    <= COMMIT;
                        wb_ex        <= has_ex;
                        eret_flush   <= ~has_ex;
                        wb_pc        <= ws_pc;
                        wb_ecode     <= ecode_next;
                        wb_vaddr     <= vaddr_next;
                        flush_target <= has_ex ? csr_eentry : csr_era;
                        pipe_kill    <= 1'b1;
                        ws_ready     <= 1'b0;
                    end
                end
                COMMIT: begin
                    state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (!mem_pending) begin
                        state_reg   <= REDIRECT;
                        flush_valid <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (flush_ready) begin
                        state_reg   <= IDLE;
                        flush_valid <= 1'b0;
                        pipe_kill   <= 1'b0;
                        ws_ready    <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Scoreboarded bench for exc_commit_ctrl: directed events with hand-computed
// CSR pulses and redirect targets, plus per-cycle sequencing checks.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid, ws_ready;
    logic [31:0] ws_pc, ws_vaddr;
    logic        ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale, ws_ertn;
    logic        int_pending, crmd_ie;
    logic [31:0] csr_eentry, csr_era;
    logic        ws_commit_ok, wb_ex, eret_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr;
    logic        mem_pending, pipe_kill, flush_valid, flush_ready;
    logic [31:0] flush_target;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_ex;
        logic [5:0]  ecode;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } exp_t;

    exp_t        ev_q[$];
    logic [31:0] tgt_q[$];

    always #5 clk = ~clk;

    exc_commit_ctrl dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_ready(ws_ready),
        .ws_pc(ws_pc), .ws_vaddr(ws_vaddr),
        .ws_ex_adef(ws_ex_adef), .ws_ex_ine(ws_ex_ine), .ws_ex_sys(ws_ex_sys),
        .ws_ex_brk(ws_ex_brk), .ws_ex_ale(ws_ex_ale), .ws_ertn(ws_ertn),
        .int_pending(int_pending), .crmd_ie(crmd_ie),
        .csr_eentry(csr_eentry), .csr_era(csr_era),
        .ws_commit_ok(ws_commit_ok),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .eret_flush(eret_flush),
        .mem_pending(mem_pending), .pipe_kill(pipe_kill),
        .flush_valid(flush_valid), .flush_target(flush_target), .flush_ready(flush_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses the CSR file or hands off a redirect.
    always @(negedge clk) begin
        if (!reset) begin
            check("pulse_exclusive", 32'(wb_ex & eret_flush), 32'd0);
            if (wb_ex | eret_flush) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = ev_q.pop_front();
                    check("wb_ex", 32'(wb_ex), 32'(e.is_ex));
                    check("eret_flush", 32'(eret_flush), 32'(!e.is_ex));
                    if (e.is_ex) check("wb_ecode", 32'(wb_ecode), 32'(e.ecode));
                    check("wb_esubcode", 32'(wb_esubcode), 32'd0);
                    check("wb_pc", wb_pc, e.pc);
                    check("wb_vaddr", wb_vaddr, e.vaddr);
                    $display("event pc=0x%08h ex=%0b ertn=%0b ecode=0x%02h vaddr=0x%08h",
                             wb_pc, wb_ex, eret_flush, wb_ecode, wb_vaddr);
                end
            end
            if (flush_valid & flush_ready) begin
                if (tgt_q.size() == 0) begin
                    check("unexpected_redirect", 32'd1, 32'd0);
                end else begin
                    logic [31:0] t;
                    t = tgt_q.pop_front();
                    check("flush_target_accept", flush_target, t);
                    $display("redirect target=0x%08h", flush_target);
                end
            end
        end
    end

    // f = {int_pending, adef, ine, sys, brk, ale, ertn}; d = mem_pending cycles in DRAIN;
    // r = cycles flush_ready stays low in REDIRECT.
    task automatic run_event(input logic [6:0] f, input logic ie, input logic [31:0] pc,
                             input logic [31:0] vaddr, input logic exp_ex, input logic [5:0] exp_ec,
                             input logic [31:0] exp_va, input logic [31:0] exp_tgt,
                             input int d, input int r);
        exp_t e;
        bit   busy, in_redir;
        @(posedge clk); #1;
        ws_valid = 1'b1;
        {int_pending, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale, ws_ertn} = f;
        crmd_ie     = ie;
        ws_pc       = pc;
        ws_vaddr    = vaddr;
        mem_pending = (d > 0);
        flush_ready = (r == 0);
        e.is_ex = exp_ex; e.ecode = exp_ec; e.pc = pc; e.vaddr = exp_va;
        ev_q.push_back(e);
        tgt_q.push_back(exp_tgt);
        @(negedge clk);
        check("ws_ready_at_T", 32'(ws_ready), 32'd1);
        check("commit_ok_at_T", 32'(ws_commit_ok), 32'd0);
        for (int k = 1; k <= 4 + d + r; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                {int_pending, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale, ws_ertn} = '0;
            end
            if (k == 2 + d) mem_pending = 1'b0;
            if (r > 0 && k == 3 + d + r) flush_ready = 1'b1;
            @(negedge clk);
            busy     = (k <= 3 + d + r);
            in_redir = (k >= 3 + d) && busy;
            check("pulse_timing", 32'(wb_ex | eret_flush), 32'(k == 1));
            check("pipe_kill", 32'(pipe_kill), 32'(busy));
            check("ws_ready", 32'(ws_ready), 32'(!busy));
            check("flush_valid", 32'(flush_valid), 32'(in_redir));
            check("ws_commit_ok", 32'(ws_commit_ok), 32'(!busy));
            if (in_redir) check("flush_target_hold", flush_target, exp_tgt);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ws_ready"}, 32'(ws_ready), 32'd1);
        check({tag, "_wb_ex"}, 32'(wb_ex), 32'd0);
        check({tag, "_eret_flush"}, 32'(eret_flush), 32'd0);
        check({tag, "_pipe_kill"}, 32'(pipe_kill), 32'd0);
        check({tag, "_flush_valid"}, 32'(flush_valid), 32'd0);
        check({tag, "_wb_ecode"}, 32'(wb_ecode), 32'd0);
        check({tag, "_wb_esubcode"}, 32'(wb_esubcode), 32'd0);
        check({tag, "_wb_pc"}, wb_pc, 32'd0);
        check({tag, "_wb_vaddr"}, wb_vaddr, 32'd0);
        check({tag, "_flush_target"}, flush_target, 32'd0);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        ws_valid = 1'b0; ws_pc = '0; ws_vaddr = '0;
        {int_pending, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale, ws_ertn} = '0;
        crmd_ie = 1'b0; mem_pending = 1'b0; flush_ready = 1'b0;
        csr_eentry = 32'h1C008000;
        csr_era    = 32'h1C000204;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        run_event(7'b0001000, 1'b0, 32'h1C000100, 32'hDEAD0000, 1'b1, 6'h0B, 32'h0, 32'h1C008000, 0, 0);
        run_event(7'b0000001, 1'b0, 32'h1C000200, 32'h0, 1'b0, 6'h00, 32'h0, 32'h1C000204, 0, 0);
        run_event(7'b1010001, 1'b1, 32'h1C000300, 32'h0, 1'b1, 6'h00, 32'h0, 32'h1C008000, 0, 0);
        run_event(7'b1010001, 1'b0, 32'h1C000300, 32'h0, 1'b1, 6'h0D, 32'h0, 32'h1C008000, 0, 0);
        run_event(7'b0000010, 1'b0, 32'h1C000400, 32'h3, 1'b1, 6'h09, 32'h3, 32'h1C008000, 5, 0);
        run_event(7'b0100000, 1'b0, 32'h1C000501, 32'h1234, 1'b1, 6'h08, 32'h1C000501, 32'h1C008000, 0, 3);
        run_event(7'b0000100, 1'b0, 32'h1C000600, 32'h0, 1'b1, 6'h0C, 32'h1C000501, 32'h1C008000, 0, 0);
        run_event(7'b0100010, 1'b0, 32'h1C000700, 32'h5, 1'b1, 6'h08, 32'h1C000700, 32'h1C008000, 0, 0);

        // Masked interrupt with a valid instruction: plain commit, no sequence.
        @(posedge clk); #1;
        ws_valid = 1'b1; int_pending = 1'b1; crmd_ie = 1'b0; flush_ready = 1'b0;
        @(negedge clk);
        check("masked_int_commit_ok", 32'(ws_commit_ok), 32'd1);
        // Enabled interrupt without a writeback instruction: not sampled.
        @(posedge clk); #1;
        ws_valid = 1'b0; crmd_ie = 1'b1;
        @(negedge clk);
        check("no_valid_commit_ok", 32'(ws_commit_ok), 32'd0);
        @(posedge clk); #1;
        int_pending = 1'b0; crmd_ie = 1'b0;
        @(negedge clk);
        check("no_valid_no_kill", 32'(pipe_kill), 32'd0);
        check("no_valid_ready", 32'(ws_ready), 32'd1);
        $display("idle checks done");

        // Reset in the middle of a drain.
        @(posedge clk); #1;
        ws_valid = 1'b1; ws_ex_ale = 1'b1; ws_pc = 32'h1C000800; ws_vaddr = 32'h44;
        mem_pending = 1'b1; flush_ready = 1'b1;
        e.is_ex = 1'b1; e.ecode = 6'h09; e.pc = 32'h1C000800; e.vaddr = 32'h44;
        ev_q.push_back(e);
        @(posedge clk); #1;
        ws_ex_ale = 1'b0; ws_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_pipe_kill", 32'(pipe_kill), 32'd1);
        check("drain_flush_valid", 32'(flush_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_pending = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        $display("reset in DRAIN done");

        run_event(7'b0001000, 1'b0, 32'h1C000900, 32'h0, 1'b1, 6'h0B, 32'h0, 32'h1C008000, 1, 1);

        @(posedge clk); #1;
        ws_valid = 1'b0; flush_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("ev_q_drained", 32'(ev_q.size()), 32'd0);
        check("tgt_q_drained", 32'(tgt_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
